// File: rtl/ahb_apb_pkg.sv
// Shared types and constants for the AHB-Lite to APB3 bridge.
// Contents: FSM state enum, HTRANS/HRESP encodings, clog2 width helper.
package ahb_apb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WDATA  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/apb_slot_mux.sv
// Combinational return-path mux: picks PRDATA/PREADY/PSLVERR of one slot.
// Ports: i_slot index, i_prdata/i_pready/i_pslverr per slot, o_* selected.
module apb_slot_mux
    import ahb_apb_pkg::*;
#(
    parameter int NUM_SLV = 4,
    parameter int SW      = 2
) (
    input  logic [SW-1:0]         i_slot,
    input  logic [32*NUM_SLV-1:0] i_prdata,
    input  logic [NUM_SLV-1:0]    i_pready,
    input  logic [NUM_SLV-1:0]    i_pslverr,
    output logic [31:0]           o_prdata,
    output logic                  o_pready,
    output logic                  o_pslverr
);

    always_comb begin
        o_prdata  = '0;
        o_pready  = 1'b0;
        o_pslverr = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (i_slot == SW'(i)) begin
                o_prdata  = i_prdata[32*i +: 32];
                o_pready  = i_pready[i];
                o_pslverr = i_pslverr[i];
            end
        end
    end

endmodule

// File: rtl/ahb_apb_bridge_n.sv
// AHB-Lite to APB3 bridge with an integrated NUM_SLV-slot address decoder.
// Ports: AHB slave side (H*), APB master side (P*, per-slot PSEL/PREADY/
// PSLVERR/PRDATA). Optional PREADY timeout: APB_BRIDGE_TIMEOUT_EN.
module ahb_apb_bridge_n
    import ahb_apb_pkg::*;
#(
    parameter int NUM_SLV     = 4,
    parameter int SLOT_AW     = 12,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic                  HREADY,
    input  logic                  HWRITE,
    input  logic [1:0]            HTRANS,
    input  logic [31:0]           HADDR,
    input  logic [31:0]           HWDATA,
    output logic [31:0]           HRDATA,
    output logic                  HREADYOUT,
    output logic [1:0]            HRESP,
    output logic [31:0]           PADDR,
    output logic [31:0]           PWDATA,
    output logic                  PWRITE,
    output logic                  PENABLE,
    output logic [NUM_SLV-1:0]    PSEL,
    input  logic [32*NUM_SLV-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]    PREADY,
    input  logic [NUM_SLV-1:0]    PSLVERR
);

    localparam int SW  = clog2(NUM_SLV);
    localparam int SWI = (SW < 1) ? 1 : SW;

    if (NUM_SLV < 1 || NUM_SLV > 16) begin : g_bad_nslv
        $error("NUM_SLV out of range");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_to
        $error("TIMEOUT_CYC out of range");
    end

    state_t         r_state;
    state_t         w_next;
    logic [SWI-1:0] r_slot;
    logic [SWI-1:0] w_slot;
    logic [31:0]    r_paddr;
    logic [31:0]    r_pwdata;
    logic [31:0]    r_hrdata;
    logic           r_pwrite;
    logic           w_cap;
    logic           w_miss;
    logic           w_upper_nz;
    logic           w_sel_en;
    logic [31:0]    w_prdata;
    logic           w_pready;
    logic           w_pslverr;
    logic           w_timeout;

    if (SW == 0) begin : g_one
        assign w_slot = '0;
    end else begin : g_many
        assign w_slot = HADDR[SLOT_AW +: SW];
    end

    // Anything above the slot field must be zero for a hit.
    assign w_upper_nz = |(HADDR >> (SLOT_AW + SW));
    assign w_miss     = w_upper_nz | (int'(w_slot) >= NUM_SLV);
    assign w_cap      = HSEL & HREADY & HTRANS[1]
                      & ((r_state == ST_IDLE) | (r_state == ST_ERR2));

    apb_slot_mux #(
        .NUM_SLV (NUM_SLV),
        .SW      (SWI)
    ) u_mux (
        .i_slot    (r_slot),
        .i_prdata  (PRDATA),
        .i_pready  (PREADY),
        .i_pslverr (PSLVERR),
        .o_prdata  (w_prdata),
        .o_pready  (w_pready),
        .o_pslverr (w_pslverr)
    );

`ifdef APB_BRIDGE_TIMEOUT_EN
    logic [15:0] r_cnt;

    // Cleared in SETUP so it starts at zero on the first ACCESS cycle.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_cnt <= '0;
        end else if (r_state == ST_SETUP) begin
            r_cnt <= '0;
        end else if (r_state == ST_ACCESS && !w_pready) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // Count reaches TIMEOUT_CYC at the end of this cycle.
    assign w_timeout = (r_cnt == 16'(TIMEOUT_CYC - 1)) & ~w_pready;
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_ERR2: begin
                if (!w_cap)      w_next = ST_IDLE;
                else if (w_miss) w_next = ST_ERR1;
                else if (HWRITE) w_next = ST_WDATA;
                else             w_next = ST_SETUP;
            end
            ST_WDATA:  w_next = ST_SETUP;
            ST_SETUP:  w_next = ST_ACCESS;
            ST_ACCESS: begin
                if (w_pready)       w_next = w_pslverr ? ST_ERR1 : ST_IDLE;
                else if (w_timeout) w_next = ST_ERR1;
            end
            ST_ERR1:   w_next = ST_ERR2;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        PENABLE   = 1'b0;
        w_sel_en  = 1'b0;
        case (r_state)
            ST_WDATA:  HREADYOUT = 1'b0;
            ST_SETUP: begin
                HREADYOUT = 1'b0;
                w_sel_en  = 1'b1;
            end
            ST_ACCESS: begin
                HREADYOUT = 1'b0;
                w_sel_en  = 1'b1;
                PENABLE   = 1'b1;
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
            end
            ST_ERR2:   HRESP = HRESP_ERROR;
            default:   HREADYOUT = 1'b1;
        endcase
    end

    always_comb begin
        PSEL = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            PSEL[i] = w_sel_en & (r_slot == SWI'(i));
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_slot   <= '0;
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
            r_hrdata <= '0;
        end else begin
            if (w_cap) begin
                r_slot   <= w_slot;
                r_paddr  <= HADDR;
                r_pwrite <= HWRITE;
            end
            if (r_state == ST_WDATA) begin
                r_pwdata <= HWDATA;
            end
            if (r_state == ST_ACCESS && w_pready && !w_pslverr && !r_pwrite) begin
                r_hrdata <= w_prdata;
            end
        end
    end

    assign PADDR  = r_paddr;
    assign PWRITE = r_pwrite;
    assign PWDATA = r_pwdata;
    assign HRDATA = r_hrdata;

endmodule

// File: tb/tb_ahb_apb_bridge_n.sv
// Directed testbench for ahb_apb_bridge_n (NUM_SLV=4, TIMEOUT_CYC=8).
// Covers reads, writes, waits, slave error, decode miss, timeout, reset.
module tb_ahb_apb_bridge_n;

    localparam int N = 4;

    logic          HCLK;
    logic          HRESETn;
    logic          HSEL;
    logic          HREADY;
    logic          HWRITE;
    logic [1:0]    HTRANS;
    logic [31:0]   HADDR;
    logic [31:0]   HWDATA;
    logic [31:0]   HRDATA;
    logic          HREADYOUT;
    logic [1:0]    HRESP;
    logic [31:0]   PADDR;
    logic [31:0]   PWDATA;
    logic          PWRITE;
    logic          PENABLE;
    logic [N-1:0]  PSEL;
    logic [32*N-1:0] PRDATA;
    logic [N-1:0]  PREADY;
    logic [N-1:0]  PSLVERR;

    int n_cmp = 0;
    int n_err = 0;

    ahb_apb_bridge_n #(
        .NUM_SLV     (N),
        .SLOT_AW     (12),
        .TIMEOUT_CYC (8)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HREADY    (HREADY),
        .HWRITE    (HWRITE),
        .HTRANS    (HTRANS),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PWRITE    (PWRITE),
        .PENABLE   (PENABLE),
        .PSEL      (PSEL),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Drive one address phase, clock the capture edge, then park the bus.
    task automatic issue(input logic [31:0] addr, input logic wr);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HADDR  = addr;
        HWRITE = wr;
        tick();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
    endtask

    initial begin
        HRESETn = 1'b0;
        HSEL    = 1'b0;
        HREADY  = 1'b1;
        HWRITE  = 1'b0;
        HTRANS  = 2'b00;
        HADDR   = '0;
        HWDATA  = '0;
        PREADY  = '1;
        PSLVERR = '0;
        PRDATA[0*32 +: 32] = 32'h1111_0000;
        PRDATA[1*32 +: 32] = 32'h2222_0001;
        PRDATA[2*32 +: 32] = 32'hA5A5_0001;
        PRDATA[3*32 +: 32] = 32'h3333_0003;
        tick();
        tick();
        chk("rst_hreadyout", HREADYOUT, 1);
        chk("rst_hresp", HRESP, 0);
        chk("rst_hrdata", HRDATA, 0);
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        HRESETn = 1'b1;
        tick();

        // Read slot 2, zero wait.
        issue(32'h0000_2010, 1'b0);
        chk("rd_setup_psel", PSEL, 4'b0100);
        chk("rd_setup_pen", PENABLE, 0);
        chk("rd_setup_hrdy", HREADYOUT, 0);
        chk("rd_paddr", PADDR, 32'h0000_2010);
        tick();
        chk("rd_acc_psel", PSEL, 4'b0100);
        chk("rd_acc_pen", PENABLE, 1);
        tick();
        chk("rd_done_hrdy", HREADYOUT, 1);
        chk("rd_done_hrdata", HRDATA, 32'hA5A5_0001);
        chk("rd_done_psel", PSEL, 0);

        // Write slot 1.
        issue(32'h0000_1004, 1'b1);
        HWDATA = 32'h0000_00C3;
        chk("wr_wdata_hrdy", HREADYOUT, 0);
        chk("wr_wdata_psel", PSEL, 0);
        tick();
        HWDATA = 32'hDEAD_BEEF;
        chk("wr_setup_psel", PSEL, 4'b0010);
        chk("wr_pwdata", PWDATA, 32'h0000_00C3);
        chk("wr_pwrite", PWRITE, 1);
        chk("wr_setup_hrdy", HREADYOUT, 0);
        tick();
        chk("wr_acc_pen", PENABLE, 1);
        chk("wr_acc_hrdy", HREADYOUT, 0);
        tick();
        chk("wr_done_hrdy", HREADYOUT, 1);
        chk("wr_hrdata_keep", HRDATA, 32'hA5A5_0001);

        // Read slot 1 with two wait cycles; slot 0 error must be ignored.
        PREADY[1]  = 1'b0;
        PSLVERR[0] = 1'b1;
        issue(32'h0000_1000, 1'b0);
        tick();
        tick();
        chk("wait_acc_pen", PENABLE, 1);
        chk("wait_acc_hrdy", HREADYOUT, 0);
        tick();
        PREADY[1] = 1'b1;
        chk("wait_acc2_psel", PSEL, 4'b0010);
        tick();
        chk("wait_done_hrdy", HREADYOUT, 1);
        chk("wait_done_hresp", HRESP, 0);
        chk("wait_done_hrdata", HRDATA, 32'h2222_0001);
        PSLVERR[0] = 1'b0;

        // Back-to-back: capture slot 3 read in the completion cycle.
        issue(32'h0000_3000, 1'b0);
        chk("b2b_setup_psel", PSEL, 4'b1000);
        tick();
        tick();
        chk("b2b_done_hrdata", HRDATA, 32'h3333_0003);
        issue(32'h0000_2000, 1'b0);
        chk("b2b2_psel", PSEL, 4'b0100);
        tick();
        tick();
        chk("b2b2_hrdata", HRDATA, 32'hA5A5_0001);

        // Slave error on slot 3.
        PSLVERR[3] = 1'b1;
        issue(32'h0000_3000, 1'b0);
        tick();
        chk("serr_acc_psel", PSEL, 4'b1000);
        tick();
        chk("serr_e1_hresp", HRESP, 1);
        chk("serr_e1_hrdy", HREADYOUT, 0);
        chk("serr_e1_psel", PSEL, 0);
        tick();
        chk("serr_e2_hresp", HRESP, 1);
        chk("serr_e2_hrdy", HREADYOUT, 1);
        tick();
        chk("serr_idle_hresp", HRESP, 0);
        chk("serr_hrdata_keep", HRDATA, 32'hA5A5_0001);
        PSLVERR[3] = 1'b0;

        // Decode miss on slot 5, then capture a slot 0 read in ERR2.
        issue(32'h0000_5000, 1'b0);
        chk("miss_e1_hresp", HRESP, 1);
        chk("miss_e1_hrdy", HREADYOUT, 0);
        chk("miss_e1_psel", PSEL, 0);
        tick();
        chk("miss_e2_hresp", HRESP, 1);
        chk("miss_e2_hrdy", HREADYOUT, 1);
        chk("miss_e2_psel", PSEL, 0);
        issue(32'h0000_0008, 1'b0);
        chk("err2cap_psel", PSEL, 4'b0001);
        chk("err2cap_hresp", HRESP, 0);
        tick();
        tick();
        chk("err2cap_hrdata", HRDATA, 32'h1111_0000);

        // Miss from nonzero bits above the slot field.
        issue(32'h0001_0000, 1'b0);
        chk("miss_hi_hresp", HRESP, 1);
        chk("miss_hi_psel", PSEL, 0);
        tick();
        tick();

        // Ignored transfers: BUSY, and NONSEQ with HSEL low.
        HSEL   = 1'b1;
        HTRANS = 2'b01;
        HADDR  = 32'h0000_2000;
        tick();
        chk("busy_hrdy", HREADYOUT, 1);
        chk("busy_psel", PSEL, 0);
        chk("busy_hresp", HRESP, 0);
        HSEL   = 1'b0;
        HTRANS = 2'b10;
        tick();
        chk("nosel_hrdy", HREADYOUT, 1);
        chk("nosel_psel", PSEL, 0);
        HTRANS = 2'b00;

`ifdef APB_BRIDGE_TIMEOUT_EN
        // Slot 0 stalls: 8 ACCESS cycles, then ERROR.
        PREADY[0] = 1'b0;
        issue(32'h0000_0000, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("to_acc_pen", PENABLE, 1);
        end
        tick();
        chk("to_e1_psel", PSEL, 0);
        chk("to_e1_pen", PENABLE, 0);
        chk("to_e1_hresp", HRESP, 1);
        chk("to_e1_hrdy", HREADYOUT, 0);
        tick();
        chk("to_e2_hresp", HRESP, 1);
        tick();
        // PREADY on the 8th ACCESS cycle wins.
        PRDATA[0*32 +: 32] = 32'h0BAD_F00D;
        issue(32'h0000_0000, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 7) PREADY[0] = 1'b1;
        end
        tick();
        chk("to_ok_hresp", HRESP, 0);
        chk("to_ok_hrdy", HREADYOUT, 1);
        chk("to_ok_hrdata", HRDATA, 32'h0BAD_F00D);
`else
        // Without the timeout a long stall just waits.
        PREADY[0] = 1'b0;
        PRDATA[0*32 +: 32] = 32'h0BAD_F00D;
        issue(32'h0000_0000, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        chk("stall_pen", PENABLE, 1);
        chk("stall_hresp", HRESP, 0);
        chk("stall_hrdy", HREADYOUT, 0);
        PREADY[0] = 1'b1;
        tick();
        chk("stall_done_hrdy", HREADYOUT, 1);
        chk("stall_done_hrdata", HRDATA, 32'h0BAD_F00D);
`endif

        // Reset during a stalled ACCESS.
        PREADY[2] = 1'b0;
        issue(32'h0000_2000, 1'b0);
        tick();
        tick();
        chk("rstacc_pen", PENABLE, 1);
        HRESETn = 1'b0;
        tick();
        chk("rstacc_psel", PSEL, 0);
        chk("rstacc_pen0", PENABLE, 0);
        chk("rstacc_hrdy", HREADYOUT, 1);
        chk("rstacc_hresp", HRESP, 0);
        HRESETn   = 1'b1;
        PREADY[2] = 1'b1;
        tick();
        issue(32'h0000_2010, 1'b0);
        chk("post_rst_psel", PSEL, 4'b0100);
        tick();
        tick();
        chk("post_rst_hrdy", HREADYOUT, 1);
        chk("post_rst_hrdata", HRDATA, 32'hA5A5_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
